// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//
// Sequences execution of the RV32I core on the FPGA board.  Produces a
// registered, single-cycle clock enable (core_en) that gates every
// architectural state update in the core (PC, register file, writeback).
//
// Modes:
//   - free-run at a prescaled rate while run_sw is high,
//   - single-step: one instruction per accepted (debounced) step_btn press,
//   - halt on a PC breakpoint while running.
//
// Ports:
//   clk          system clock, all flops on posedge
//   n_rst        asynchronous active-low reset
//   run_sw       async level switch: 1 = run, 0 = halt
//   step_btn     async bouncy push button; each accepted press = one step
//   bp_en        breakpoint enable (quasi-static)
//   bp_addr      breakpoint PC (quasi-static)
//   PC           current core PC (PC_Next), compared before issuing a pulse
//   core_en      1-cycle enable: the core executes one instruction this cycle
//   halted       1 while the controller sits in HALT
//   bp_hit       sticky breakpoint flag, cleared by the next core_en
//   instr_count  number of core_en pulses since reset, wraps modulo 2^CNT_W
//
// Parameters:
//   CLK_DIV      clk cycles between core_en pulses in RUN (>=1)
//   DEB_CYCLES   cycles step_btn must be stable before its level is accepted (>=1)
//   CNT_W        width of instr_count
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      PC,
  output logic             core_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);

  // Counter widths; a divider/debounce of 1 still needs a 1-bit counter.
  localparam int unsigned PW = (CLK_DIV    > 1) ? $clog2(CLK_DIV)    : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            run_meta;
  logic            run_s;
  logic            btn_meta;
  logic            btn_s;

  logic            btn_db;
  logic            btn_db_q;
  logic [DW-1:0]   deb_cnt;
  logic            step_req;

  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_next;
  logic            tick;

  logic            skip_bp;
  logic            skip_next;
  logic            bp_next;
  logic            en_next;
  logic            bp_match;

  // ---------------------------------------------------------------------------
  // Input synchronizers (2 flops each)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      run_meta <= run_sw;
      run_s    <= run_meta;
      btn_meta <= step_btn;
      btn_s    <= btn_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Button debounce: the new level is accepted only after btn_s has differed
  // from the accepted level for DEB_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s != btn_db) begin
        if (deb_cnt == DEB_LAST) begin
          btn_db  <= btn_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // One-cycle strobe on each accepted press (rising edge of btn_db).
  assign step_req = btn_db & ~btn_db_q;

  // ---------------------------------------------------------------------------
  // Prescaler tick and breakpoint compare
  // ---------------------------------------------------------------------------
  assign tick     = (state == RUN) && (presc == PRESC_LAST);
  assign bp_match = bp_en && (PC == bp_addr);

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= HALT;
      presc   <= '0;
      core_en <= 1'b0;
      skip_bp <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      state   <= state_next;
      presc   <= presc_next;
      core_en <= en_next;
      skip_bp <= skip_next;
      bp_hit  <= bp_next;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      instr_count <= '0;
    end else if (core_en) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign halted = (state == HALT);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    en_next    = 1'b0;
    skip_next  = skip_bp;
    bp_next    = bp_hit;
    presc_next = '0;

    case (state)
      HALT: begin
        if (run_s) begin
          // Resuming from a breakpoint must not re-hit the same PC.
          state_next = RUN;
          skip_next  = 1'b1;
        end else if (step_req) begin
          state_next = STEP;
        end
      end

      RUN: begin
        if (!run_s) begin
          state_next = HALT;
        end else if (tick) begin
          if (bp_match && !skip_bp) begin
            state_next = HALT;
            bp_next    = 1'b1;
          end else begin
            en_next   = 1'b1;
            skip_next = 1'b0;
          end
        end
      end

      STEP: begin
        en_next    = 1'b1;
        state_next = HALT;
      end

      default: begin
        state_next = HALT;
      end
    endcase

    // A pulse and a fresh hit are mutually exclusive, so clearing here is safe.
    if (en_next) begin
      bp_next = 1'b0;
    end

    // Prescaler only advances while staying in RUN; any exit restarts it.
    if ((state == RUN) && (state_next == RUN)) begin
      presc_next = tick ? '0 : presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;

  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic        clk;
  logic        n_rst;
  logic        run_sw;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] PC;
  logic        core_en;
  logic        halted;
  logic        bp_hit;
  logic [31:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  string phase = "init";

  // Reference model state (behavioural, cycle level)
  bit          m_rs1, m_rs, m_bs1, m_bs;
  bit          m_db, m_db_prev;
  int          m_diff;
  int          m_mode;
  int          m_age;
  bit          m_skip, m_bp, m_en;
  logic [31:0] m_cnt;

  // Observations from the DUT
  int          cyc_no;
  int          dut_pulses;
  logic [31:0] dut_pcs[$];
  int          pulse_at[$];

  core_run_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .DEB_CYCLES (DEB),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .PC          (PC),
    .core_en     (core_en),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rs1 = 0; m_rs = 0; m_bs1 = 0; m_bs = 0;
    m_db = 0; m_db_prev = 0; m_diff = 0;
    m_mode = M_HALT; m_age = 0;
    m_skip = 0; m_bp = 0; m_en = 0;
    m_cnt = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit run_now, step_now, tick_now, hit_now, nskip, nbp, nen;
    int nmode;
    run_now  = m_rs;
    step_now = m_db && !m_db_prev;
    tick_now = (m_mode == M_RUN) && ((m_age % CLK_DIV) == CLK_DIV - 1);
    hit_now  = bp_en && (PC == bp_addr) && !m_skip;
    nmode = m_mode; nskip = m_skip; nbp = m_bp; nen = 0;
    if (m_mode == M_HALT) begin
      if (run_now) begin nmode = M_RUN; nskip = 1; end
      else if (step_now) nmode = M_STEP;
    end else if (m_mode == M_RUN) begin
      if (!run_now) nmode = M_HALT;
      else if (tick_now && hit_now) begin nmode = M_HALT; nbp = 1; end
      else if (tick_now) begin nen = 1; nskip = 0; end
    end else begin
      nen = 1; nmode = M_HALT;
    end
    if (nen) nbp = 0;
    if (m_en) m_cnt = m_cnt + 32'd1;
    m_age  = (m_mode == M_RUN && nmode == M_RUN) ? m_age + 1 : 0;
    m_mode = nmode; m_skip = nskip; m_bp = nbp; m_en = nen;
    m_db_prev = m_db;
    if (m_bs != m_db) begin
      m_diff++;
      if (m_diff == DEB) begin m_db = m_bs; m_diff = 0; end
    end else begin
      m_diff = 0;
    end
    m_rs = m_rs1; m_rs1 = run_sw;
    m_bs = m_bs1; m_bs1 = step_btn;
  endtask

  task automatic check_outs();
    chk({phase, ":core_en"}, 32'(core_en), 32'(m_en));
    chk({phase, ":halted"}, 32'(halted), 32'(m_mode == M_HALT));
    chk({phase, ":bp_hit"}, 32'(bp_hit), 32'(m_bp));
    chk({phase, ":instr_count"}, instr_count, m_cnt);
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge,
  // and the PC advances like a core would after each executed instruction.
  task automatic cyc();
    @(posedge clk);
    if (!n_rst) model_reset();
    else model_edge();
    @(negedge clk);
    cyc_no++;
    check_outs();
    if (core_en === 1'b1) begin
      dut_pulses++;
      dut_pcs.push_back(PC);
      pulse_at.push_back(cyc_no);
      PC = PC + 32'd4;
    end
  endtask

  initial begin
    bit found;
    int lat;
    int p0;

    // ---- 1: reset with run_sw held high ----
    phase = "reset";
    run_sw = 1'b1; step_btn = 1'b0; bp_en = 1'b0; bp_addr = '0; PC = '0;
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("reset:core_en", 32'(core_en), 32'd0);
    chk("reset:halted", 32'(halted), 32'd1);
    repeat (3) cyc();
    chk("reset_hold:halted", 32'(halted), 32'd1);
    n_rst = 1'b1;
    phase = "run_from_reset";
    cyc_no = 0; dut_pulses = 0; pulse_at.delete(); dut_pcs.delete();
    repeat (24) cyc();
    chk("s1:pulses", 32'(dut_pulses), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("s1:pulse_cycle%0d", i), 32'(pulse_at[i]), 32'(7 + 4 * i));
    chk("s1:instr_count", instr_count, 32'd5);

    run_sw = 1'b0;
    phase = "stop";
    repeat (6) cyc();
    chk("s1:halted_after_stop", 32'(halted), 32'd1);
    chk("s1:count_after_stop", instr_count, 32'd5);

    // ---- 2: bouncy single step ----
    phase = "bounce_step";
    dut_pulses = 0;
    step_btn = 1'b1; cyc();
    step_btn = 1'b0; cyc();
    step_btn = 1'b1; cyc();
    step_btn = 1'b0; cyc();
    step_btn = 1'b1;
    repeat (10) cyc();
    step_btn = 1'b0;
    repeat (8) cyc();
    chk("s2:pulses", 32'(dut_pulses), 32'd1);
    chk("s2:instr_count", instr_count, 32'd6);
    chk("s2:halted", 32'(halted), 32'd1);

    // ---- 3: run into breakpoint at 0x10 ----
    phase = "bp_run";
    PC = '0; bp_addr = 32'h10; bp_en = 1'b1; run_sw = 1'b1;
    dut_pcs.delete(); dut_pulses = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (bp_hit === 1'b1) found = 1;
    end
    chk("s3:bp_seen", 32'(found), 32'd1);
    chk("s3:pulses", 32'(dut_pulses), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("s3:pc%0d", i), dut_pcs[i], 32'(4 * i));
    chk("s3:pc_at_halt", PC, 32'h10);
    chk("s3:halted", 32'(halted), 32'd1);
    chk("s3:instr_count", instr_count, 32'd10);
    run_sw = 1'b0;
    phase = "bp_hold";
    repeat (8) cyc();
    chk("s3:halted_hold", 32'(halted), 32'd1);
    chk("s3:bp_sticky", 32'(bp_hit), 32'd1);

    // ---- 4: resume from the breakpoint ----
    phase = "bp_resume";
    run_sw = 1'b1;
    dut_pcs.delete(); dut_pulses = 0;
    repeat (20) cyc();
    chk("s4:pulses", 32'(dut_pulses), 32'd4);
    chk("s4:first_pc", dut_pcs[0], 32'h10);
    chk("s4:last_pc", dut_pcs[3], 32'h1C);
    chk("s4:bp_cleared", 32'(bp_hit), 32'd0);
    chk("s4:running", 32'(halted), 32'd0);
    chk("s4:instr_count", instr_count, 32'd14);

    // ---- 5: drop run_sw so it lands on the tick cycle ----
    phase = "drop_on_tick";
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc();
      if (core_en === 1'b1) found = 1;
    end
    chk("s5:pulse_seen", 32'(found), 32'd1);
    cyc();
    run_sw = 1'b0;
    dut_pulses = 0;
    cyc(); cyc();
    chk("s5:still_run", 32'(halted), 32'd0);
    cyc();
    chk("s5:halted", 32'(halted), 32'd1);
    chk("s5:no_pulse", 32'(core_en), 32'd0);
    repeat (6) cyc();
    chk("s5:pulses", 32'(dut_pulses), 32'd0);

    // ---- 6: counter wrap, then reset during a pulse ----
    phase = "wrap";
    bp_en = 1'b0;
    force dut.instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count;
    m_cnt = 32'hFFFF_FFFF;
    chk("s6:preload", instr_count, 32'hFFFF_FFFF);
    step_btn = 1'b1;
    found = 0; lat = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      lat++;
      if (core_en === 1'b1) found = 1;
    end
    chk("s6:step_seen", 32'(found), 32'd1);
    chk("s6:step_latency", 32'(lat), 32'd7);
    cyc();
    chk("s6:wrapped", instr_count, 32'd0);
    step_btn = 1'b0;
    repeat (8) cyc();
    step_btn = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (core_en === 1'b1) found = 1;
    end
    chk("s6:step2_seen", 32'(found), 32'd1);
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("s6:reset_core_en", 32'(core_en), 32'd0);
    chk("s6:reset_halted", 32'(halted), 32'd1);
    chk("s6:reset_count", instr_count, 32'd0);
    cyc();
    n_rst = 1'b1;
    step_btn = 1'b0;
    repeat (10) cyc();

    // ---- randomized traffic against the model ----
    phase = "random";
    PC = '0;
    p0 = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 99) == 0) begin
        bp_en   = 1'($urandom_range(0, 1));
        bp_addr = PC + 32'(4 * $urandom_range(0, 6));
      end
      if ($urandom_range(0, 399) == 0) begin
        n_rst = 1'b0;
        cyc();
        n_rst = 1'b1;
        p0++;
      end else begin
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
